mux4_lut_reg: RTL and testbench

- Registered 4-input single-output Boolean function unit; built as a 16:1 multiplexer tree.
- Its select is {w3,w2,w1,w0} and its data is a 16-bit truth-table register.
- The default table makes the block a 2:1 mux: w3 selects between w0 and w1.
- Sits as a small glue/steering cell; the table can be reprogrammed at runtime through a write port.

---
 rtl/mux4_lut_pkg.sv | 25 ++
 rtl/mux4_lut_reg_mux4to1.sv | 24 ++
 rtl/mux4_lut_reg.sv | 79 +++++++
 tb/tb_mux4_lut_reg.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mux4_lut_pkg.sv
// rtl/mux4_lut_pkg.sv - shared constants and types for the mux4_lut_reg function unit
//
// Contents:
//   MUX4_SEL_W          width of the lookup index {w3,w2,w1,w0}
//   MUX4_TABLE_DEFAULT  reset truth table, f = w3 ? w1 : w0 (w2 don't-care)
//   mux4_idx_t          lookup index type
//   mux4_table_t        16-entry truth-table type
//   mux4_index()        packs the four select bits into an index
package mux4_lut_pkg;

  localparam int MUX4_SEL_W = 4;
  localparam int MUX4_TABLE_W = 1 << MUX4_SEL_W;

  typedef logic [MUX4_SEL_W-1:0]   mux4_idx_t;
  typedef logic [MUX4_TABLE_W-1:0] mux4_table_t;

  localparam mux4_table_t MUX4_TABLE_DEFAULT = 16'hCCAA;

  // w3 is the MSB of the index, w0 the LSB.
  function automatic mux4_idx_t mux4_index(input logic w3, input logic w2,
                                           input logic w1, input logic w0);
    return {w3, w2, w1, w0};
  endfunction

endpackage

// File: rtl/mux4_lut_reg_mux4to1.sv
// rtl/mux4_lut_reg_mux4to1.sv - 4:1 single-bit multiplexer, building block of the lookup tree
//
// Ports:
//   d    input  4  data bits, d[i] selected when sel == i
//   sel  input  2  select
//   y    output 1  selected bit
module mux4to1 (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (sel)
      2'd0: y = d[0];
      2'd1: y = d[1];
      2'd2: y = d[2];
      2'd3: y = d[3];
      default: y = 1'bx;
    endcase
  end

endmodule

// File: rtl/mux4_lut_reg.sv
// rtl/mux4_lut_reg.sv - registered, runtime-reprogrammable 4-input Boolean function unit
//
// A 16-bit truth table is indexed by {w3,w2,w1,w0} through a two-level tree of
// 4:1 muxes. The table resets to TABLE_INIT and can be rewritten via cfg_we.
//
// Build option:
//   MUX4_LUT_COMB_OUT_EN  when defined, f is driven combinationally from the
//                         table (zero latency); otherwise f is registered.
//
// Ports:
//   clk       input  1   rising-edge clock
//   rst       input  1   asynchronous, active-high reset
//   w0..w3    input  1   select bits (w0 = LSB, w3 = MSB)
//   cfg_we    input  1   table write enable, sampled on clk
//   cfg_data  input  16  new truth table, loaded when cfg_we = 1
//   f         output 1   function output
module mux4_lut_reg
  import mux4_lut_pkg::*;
#(
  parameter logic [15:0] TABLE_INIT = MUX4_TABLE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w0,
  input  logic        w1,
  input  logic        w2,
  input  logic        w3,
  input  logic        cfg_we,
  input  logic [15:0] cfg_data,
  output logic        f
);

  mux4_table_t lut;
  mux4_idx_t   idx;
  logic [3:0]  level1;
  logic        lut_out;

  assign idx = mux4_index(w3, w2, w1, w0);

  // Reset wins over a write pending in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut <= TABLE_INIT;
    end else if (cfg_we) begin
      lut <= cfg_data;
    end
  end

  // First level: each mux picks one bit out of a nibble using {w1,w0}.
  for (genvar g = 0; g < 4; g++) begin : g_level1
    mux4to1 u_mux (
      .d   (lut[4*g +: 4]),
      .sel (idx[1:0]),
      .y   (level1[g])
    );
  end

  // Second level: {w3,w2} picks which nibble's result is used.
  mux4to1 u_mux_level2 (
    .d   (level1),
    .sel (idx[3:2]),
    .y   (lut_out)
  );

`ifdef MUX4_LUT_COMB_OUT_EN
  assign f = lut_out;
`else
  // lut_out reads the table as it stood before this edge, so a write on the
  // same edge only affects lookups from the following edge onwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f <= 1'b0;
    end else begin
      f <= lut_out;
    end
  end
`endif

endmodule

// File: tb/tb_mux4_lut_reg.sv
// tb/tb_mux4_lut_reg.sv - self-checking bench for mux4_lut_reg
module tb_mux4_lut_reg;

  logic        clk;
  logic        rst;
  logic [3:0]  sel;
  logic        cfg_we;
  logic [15:0] cfg_data;
  logic        f;

  int n_checks;
  int n_errors;

  logic [15:0] model_tbl;

  typedef struct {
    logic [3:0] idx;
    logic       exp;
  } vec_t;

  vec_t vecs[16];

  mux4_lut_reg dut (
    .clk      (clk),
    .rst      (rst),
    .w0       (sel[0]),
    .w1       (sel[1]),
    .w2       (sel[2]),
    .w3       (sel[3]),
    .cfg_we   (cfg_we),
    .cfg_data (cfg_data),
    .f        (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    sel      = 4'd0;
    cfg_we   = 1'b0;
    cfg_data = 16'h0000;

    // Default table is f = w3 ? w1 : w0.
    for (int i = 0; i < 16; i++) begin
      vecs[i].idx = 4'(i);
      vecs[i].exp = (i >= 8) ? ((i >> 1) & 1) == 1 : (i & 1) == 1;
    end

    // Asynchronous reset with no clock edge.
    #2 rst = 1'b1;
    #1 check("reset_f", f, 1'b0);
    tick();
    check("reset_hold", f, 1'b0);
    @(negedge clk) rst = 1'b0;
    model_tbl = 16'hCCAA;

    // Exhaustive sweep of the default table.
    for (int i = 0; i < 16; i++) begin
      sel = vecs[i].idx;
      tick();
      check($sformatf("sweep_idx%0d", i), f, vecs[i].exp);
    end

    // Async reset mid-cycle with f=1.
    sel = 4'd1;
    tick();
    check("pre_async_f1", f, 1'b1);
    #3 rst = 1'b1;
    #1 check("async_reset_f0", f, 1'b0);
    @(negedge clk) rst = 1'b0;
    tick();
    check("post_reset_idx1", f, 1'b1);

    // Reprogram to odd parity.
    cfg_we = 1'b1;
    cfg_data = 16'h6996;
    sel = 4'd0;
    tick();
    cfg_we = 1'b0;
    model_tbl = 16'h6996;
    sel = 4'd7;
    tick();
    check("parity_idx7", f, 1'b1);
    sel = 4'd15;
    tick();
    check("parity_idx15", f, 1'b0);

    // Write/read collision: lookup uses the old table.
    sel = 4'd0;
    cfg_we = 1'b1;
    cfg_data = 16'h0001;
    tick();
    check("collision_old", f, 1'b0);
    cfg_we = 1'b0;
    tick();
    check("collision_new", f, 1'b1);

    // Reset restores the table; a write pending during reset is dropped.
    cfg_we = 1'b1;
    cfg_data = 16'hFFFF;
    tick();
    check("load_ffff", f, 1'b1);
    #3 rst = 1'b1;
    tick();
    check("reset_during_write", f, 1'b0);
    @(negedge clk) begin
      rst = 1'b0;
      cfg_we = 1'b0;
    end
    model_tbl = 16'hCCAA;
    sel = 4'd0;
    tick();
    check("reset_restores_idx0", f, 1'b0);
    sel = 4'd10;
    tick();
    check("reset_restores_idx10", f, 1'b1);

    // Random lookups and writes against a plain table model.
    for (int n = 0; n < 300; n++) begin
      logic exp_f;
      sel = 4'($urandom_range(0, 15));
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_data = 16'($urandom);
      exp_f = model_tbl[sel];
      tick();
      check($sformatf("random_%0d_idx%0d", n, sel), f, exp_f);
      if (cfg_we) model_tbl = cfg_data;
    end
    cfg_we = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
